// File: rtl/serial_subtractor_if.sv
// Start/result bundle for the bit-serial subtractor; the requester is the
// master, the subtractor is the slave.
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   // Handshake: in_start is a request sampled only while out_busy is low.
   // An accepted request raises out_busy on the same edge. out_done pulses
   // for one cycle when the result is ready. Requests seen while busy are dropped.
   logic             in_start;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             out_busy;
   logic             out_done;
   logic [WIDTH-1:0] out_d;
   logic             out_borrow;
   logic             out_overflow;
   logic             out_zero;

   modport master (
      output in_start, in_a, in_b,
      input  out_busy, out_done, out_d, out_borrow, out_overflow, out_zero
   );

   modport slave (
      input  in_start, in_a, in_b,
      output out_busy, out_done, out_d, out_borrow, out_overflow, out_zero
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: D = A - B, LSB first, one
// full-subtractor step per clock through a single registered borrow.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                reset,
   serial_subtractor_if.slave  bus,
   output logic [1:0]          dbg_state_o
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] sa_q, sb_q;
   // The top result bit comes straight from the datapath on the last step,
   // so only the already-computed low bits need storage.
   logic [WIDTH-2:0] sd_q;
   logic             br_q;
   logic [CW-1:0]    cnt_q;
   logic             a_msb_q, b_msb_q;

   logic             busy_q, done_q;
   logic [WIDTH-1:0] d_q;
   logic             borrow_q, ovf_q, zero_q;

   logic             bit_a, bit_b, diff_d, br_d, last_bit;
   logic [WIDTH-1:0] sd_d;

   always_comb begin
      bit_a    = sa_q[0];
      bit_b    = sb_q[0];
      diff_d   = bit_a ^ bit_b ^ br_q;
      br_d     = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
      sd_d     = {diff_d, sd_q};
      last_bit = (cnt_q == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         sa_q     <= '0;
         sb_q     <= '0;
         sd_q     <= '0;
         br_q     <= 1'b0;
         cnt_q    <= '0;
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         d_q      <= '0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.in_start) begin
                  sa_q    <= bus.in_a;
                  sb_q    <= bus.in_b;
                  br_q    <= 1'b0;
                  cnt_q   <= '0;
                  a_msb_q <= bus.in_a[WIDTH-1];
                  b_msb_q <= bus.in_b[WIDTH-1];
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               sa_q  <= sa_q >> 1;
               sb_q  <= sb_q >> 1;
               sd_q  <= sd_d[WIDTH-1:1];
               br_q  <= br_d;
               cnt_q <= cnt_q + CW'(1);
               if (last_bit) begin
                  d_q      <= sd_d;
                  borrow_q <= br_d;
                  zero_q   <= (sd_d == '0);
                  // Overflow only when operand signs differ and the result sign flips from A.
                  ovf_q    <= (a_msb_q != b_msb_q) && (diff_d != a_msb_q);
                  done_q   <= 1'b1;
                  state_q  <= S_DONE;
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.out_busy     = busy_q;
   assign bus.out_done     = done_q;
   assign bus.out_d        = d_q;
   assign bus.out_borrow   = borrow_q;
   assign bus.out_overflow = ovf_q;
   assign bus.out_zero     = zero_q;
   assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH 8, 2 and 32: table of
// hand-computed vectors plus hold, back-to-back and reset-abort sequences.
module tb_serial_subtractor;
   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   serial_subtractor_if #(.WIDTH(8))  if8 ();
   serial_subtractor_if #(.WIDTH(2))  if2 ();
   serial_subtractor_if #(.WIDTH(32)) if32 ();
   logic [1:0] dbg8, dbg2, dbg32;

   serial_subtractor #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(if8),  .dbg_state_o(dbg8));
   serial_subtractor #(.WIDTH(2))  dut2  (.clk(clk), .reset(reset), .bus(if2),  .dbg_state_o(dbg2));
   serial_subtractor #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(if32), .dbg_state_o(dbg32));

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] d;
      logic        borrow;
      logic        ovf;
      logic        zero;
   } vec_t;

   // Expected results packed as {zero, ovf, borrow, d[31:0]}.
   logic [34:0] exp_q[$];
   logic [34:0] prev_res[int];
   int          n_cmp  = 0;
   int          n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input int sel, input logic s, input logic [31:0] a, input logic [31:0] b);
      case (sel)
         8:       begin if8.in_start  = s; if8.in_a  = a[7:0]; if8.in_b  = b[7:0]; end
         2:       begin if2.in_start  = s; if2.in_a  = a[1:0]; if2.in_b  = b[1:0]; end
         default: begin if32.in_start = s; if32.in_a = a;      if32.in_b = b;      end
      endcase
   endtask

   task automatic sample(input int sel, output logic busy, output logic done, output logic [31:0] d,
                         output logic borrow, output logic ovf, output logic zero);
      case (sel)
         8: begin
            busy = if8.out_busy; done = if8.out_done; d = {24'b0, if8.out_d};
            borrow = if8.out_borrow; ovf = if8.out_overflow; zero = if8.out_zero;
         end
         2: begin
            busy = if2.out_busy; done = if2.out_done; d = {30'b0, if2.out_d};
            borrow = if2.out_borrow; ovf = if2.out_overflow; zero = if2.out_zero;
         end
         default: begin
            busy = if32.out_busy; done = if32.out_done; d = if32.out_d;
            borrow = if32.out_borrow; ovf = if32.out_overflow; zero = if32.out_zero;
         end
      endcase
   endtask

   task automatic compare_result(input string name, input int sel, input logic [31:0] d,
                                 input logic borrow, input logic ovf, input logic zero);
      logic [34:0] e;
      if (exp_q.size() == 0) begin
         check({name, "_unexpected_done"}, 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check({name, "_d"},        d,                  e[31:0]);
         check({name, "_borrow"},   {31'b0, borrow},    {31'b0, e[32]});
         check({name, "_overflow"}, {31'b0, ovf},       {31'b0, e[33]});
         check({name, "_zero"},     {31'b0, zero},      {31'b0, e[34]});
         prev_res[sel] = e;
      end
   endtask

   // Called just after a falling edge; the start is accepted on the next rising edge.
   task automatic run_op(input string name, input int sel, input int width,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] ed,
                         input logic eb, input logic eo, input logic ez);
      logic busy, done, borrow, ovf, zero;
      logic [31:0] d;
      int cnt;
      exp_q.push_back({ez, eo, eb, ed});
      drive(sel, 1'b1, a, b);
      @(negedge clk);
      drive(sel, 1'b0, 32'h0, 32'h0);
      sample(sel, busy, done, d, borrow, ovf, zero);
      check({name, "_busy_rise"}, {31'b0, busy}, 32'd1);
      check({name, "_hold_d"}, d, prev_res[sel][31:0]);
      cnt = 0;
      done = 1'b0;
      while (!done && cnt < 60) begin
         @(negedge clk);
         cnt++;
         sample(sel, busy, done, d, borrow, ovf, zero);
         if (!done) begin
            check({name, "_hold_d"}, d, prev_res[sel][31:0]);
            check({name, "_hold_zero"}, {31'b0, zero}, {31'b0, prev_res[sel][34]});
         end
      end
      check({name, "_latency"}, cnt, width);
      if (done) begin
         check({name, "_busy_at_done"}, {31'b0, busy}, 32'd1);
         compare_result(name, sel, d, borrow, ovf, zero);
      end else begin
         exp_q.delete();
      end
      @(negedge clk);
      sample(sel, busy, done, d, borrow, ovf, zero);
      check({name, "_done_one_cycle"}, {31'b0, done}, 32'd0);
      check({name, "_busy_fall"}, {31'b0, busy}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[7];
      logic busy, done, borrow, ovf, zero;
      logic [31:0] d;
      logic [7:0] ra, rb, rd;
      int pulses;

      vecs[0] = '{32'h05, 32'h03, 32'h02, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{32'h03, 32'h05, 32'hFE, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{32'h00, 32'hFF, 32'h01, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{32'h80, 32'h01, 32'h7F, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{32'h7F, 32'hFF, 32'h80, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{32'h2A, 32'h2A, 32'h00, 1'b0, 1'b0, 1'b1};
      vecs[6] = '{32'hFF, 32'h00, 32'hFF, 1'b0, 1'b0, 1'b0};

      prev_res[8] = '0;
      prev_res[2] = '0;
      prev_res[32] = '0;

      // Clock/reset
      reset = 1'b1;
      drive(8, 1'b0, 32'h0, 32'h0);
      drive(2, 1'b0, 32'h0, 32'h0);
      drive(32, 1'b0, 32'h0, 32'h0);
      repeat (2) @(negedge clk);
      sample(8, busy, done, d, borrow, ovf, zero);
      check("reset_busy", {31'b0, busy}, 32'd0);
      check("reset_done", {31'b0, done}, 32'd0);
      check("reset_d", d, 32'd0);
      check("reset_flags", {29'b0, borrow, ovf, zero}, 32'd0);
      check("reset_state", {30'b0, dbg8}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Table-driven vectors; vecs[6] follows vecs[5] so the zero result must hold through its RUN.
      for (int i = 0; i < 7; i++) begin
         run_op($sformatf("vec%0d", i), 8, 8, vecs[i].a, vecs[i].b, vecs[i].d,
                vecs[i].borrow, vecs[i].ovf, vecs[i].zero);
      end

      // Start held high for 30 edges with operands changing every cycle.
      pulses = 0;
      for (int j = 0; j < 30; j++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         drive(8, 1'b1, {24'b0, ra}, {24'b0, rb});
         if (j % 10 == 0) begin
            rd = ra - rb;
            exp_q.push_back({(rd == 8'h00), (ra[7] != rb[7]) && (rd[7] != ra[7]), (ra < rb), 24'b0, rd});
         end
         @(negedge clk);
         sample(8, busy, done, d, borrow, ovf, zero);
         check($sformatf("b2b_done_c%0d", j), {31'b0, done}, {31'b0, (j % 10 == 8)});
         if (done) begin
            pulses++;
            compare_result($sformatf("b2b_op%0d", pulses), 8, d, borrow, ovf, zero);
         end
      end
      drive(8, 1'b0, 32'h0, 32'h0);
      check("b2b_pulse_count", pulses, 3);
      exp_q.delete();

      // Reset four cycles into a RUN aborts it.
      drive(8, 1'b1, 32'h33, 32'h11);
      @(negedge clk);
      drive(8, 1'b0, 32'h0, 32'h0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      sample(8, busy, done, d, borrow, ovf, zero);
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_done", {31'b0, done}, 32'd0);
      check("abort_d", d, 32'd0);
      check("abort_flags", {29'b0, borrow, ovf, zero}, 32'd0);
      prev_res[8] = '0;
      @(negedge clk);
      reset = 1'b0;
      run_op("post_reset", 8, 8, 32'h10, 32'h01, 32'h0F, 1'b0, 1'b0, 1'b0);

      // Parameterization: 0x05 - 0x03 truncated to 2 bits is 1 - 3 = 2 with borrow and overflow.
      run_op("w2", 2, 2, 32'h05, 32'h03, 32'h2, 1'b1, 1'b1, 1'b0);
      run_op("w32", 32, 32, 32'h05, 32'h03, 32'h2, 1'b0, 1'b0, 1'b0);
      run_op("w32_neg", 32, 32, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
